cpu_datapath: RTL and testbench

//  32-bit single-bus datapath for a 16-register load/store CPU, sequenced cycle-by-cycle by an external control unit.

---
 rtl/cpu_datapath_if.sv | 44 ++++
 rtl/cpu_datapath.sv | 166 ++++++++++++++++
 tb/tb_cpu_datapath.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control and observation bundle between the external control unit (master)
// and the single-bus CPU datapath (slave).
interface cpu_datapath_if #(
    parameter int BITS          = 32,
    parameter int TOT_REGISTERS = 23
);
    logic CONin, PCin, IRin, RYin, RZin, MARin, HILOin, OUTPUTin, INTERin, MDRin;
    logic Read, Write;
    logic INPUTout, MDRout, HILOout, RZout, PCout, Cout, INTERout, BAout, Rout;
    logic Gra, Grb, Grc, Rin;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
    logic [BITS-1:0] INPUTUnit;

    logic [BITS*TOT_REGISTERS-1:0] regSelectStreamLO, regSelectStreamHI;
    logic [BITS-1:0]   busLO, busHI;
    logic [BITS-1:0]   MARVal, IRVal, MDRVal, LOVal, HIVal, INTERHIVal, INTERLOVal;
    logic [2*BITS-1:0] RZVal;
    logic [BITS-1:0]   OUTPUTUnit, c_sign_extended;
    logic              CON;

    modport master (
        output CONin, PCin, IRin, RYin, RZin, MARin, HILOin, OUTPUTin, INTERin, MDRin,
        output Read, Write,
        output INPUTout, MDRout, HILOout, RZout, PCout, Cout, INTERout, BAout, Rout,
        output Gra, Grb, Grc, Rin,
        output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
        output INPUTUnit,
        input  regSelectStreamLO, regSelectStreamHI, busLO, busHI,
        input  MARVal, IRVal, MDRVal, LOVal, HIVal, INTERHIVal, INTERLOVal,
        input  RZVal, OUTPUTUnit, c_sign_extended, CON
    );

    modport slave (
        input  CONin, PCin, IRin, RYin, RZin, MARin, HILOin, OUTPUTin, INTERin, MDRin,
        input  Read, Write,
        input  INPUTout, MDRout, HILOout, RZout, PCout, Cout, INTERout, BAout, Rout,
        input  Gra, Grb, Grc, Rin,
        input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
        input  INPUTUnit,
        output regSelectStreamLO, regSelectStreamHI, busLO, busHI,
        output MARVal, IRVal, MDRVal, LOVal, HIVal, INTERHIVal, INTERLOVal,
        output RZVal, OUTPUTUnit, c_sign_extended, CON
    );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus load/store CPU datapath: register file, special registers,
// 64-bit ALU and word RAM, sequenced cycle-by-cycle by an external control unit.
module cpu_datapath #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int RAMSIZE   = 512
) (
    input  logic            reset,
    input  logic            clk,
    input  logic            rClk,
    cpu_datapath_if.slave   dp
);
    localparam int TOT_REGISTERS = REGISTERS + 7;
    localparam int AW            = $clog2(RAMSIZE);

    logic [BITS-1:0]   r_q [REGISTERS];
    logic [BITS-1:0]   r_d [REGISTERS];
    logic [BITS-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d, ry_q, ry_d;
    logic [BITS-1:0]   hi_q, hi_d, lo_q, lo_d, inter_hi_q, inter_hi_d, inter_lo_q, inter_lo_d;
    logic [BITS-1:0]   out_q, out_d;
    logic [2*BITS-1:0] rz_q, rz_d;
    logic              con_q, con_d;
    logic [BITS-1:0]   ram [RAMSIZE];

    logic              unused_rclk;
    assign unused_rclk = rClk;

    logic [3:0]      ra, rb, rc, rx_sel;
    logic [1:0]      c2;
    logic [BITS-1:0] c_sext, rx_val, bus_lo, bus_hi, ram_rd;
    logic [AW-1:0]   mar_idx;

    assign ra      = ir_q[26:23];
    assign rb      = ir_q[22:19];
    assign rc      = ir_q[18:15];
    assign c2      = ir_q[20:19];
    assign c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};
    assign rx_sel  = dp.Gra ? ra : dp.Grb ? rb : dp.Grc ? rc : 4'd0;
    assign rx_val  = r_q[rx_sel];
    assign mar_idx = mar_q[AW-1:0];
    assign ram_rd  = ram[mar_idx];

    // Control guarantees one-hot drive, so the bus is a plain OR of gated sources.
    always_comb begin
        bus_lo = ({BITS{dp.INPUTout}} & dp.INPUTUnit)
               | ({BITS{dp.MDRout}}   & mdr_q)
               | ({BITS{dp.HILOout}}  & lo_q)
               | ({BITS{dp.RZout}}    & rz_q[BITS-1:0])
               | ({BITS{dp.PCout}}    & pc_q)
               | ({BITS{dp.Cout}}     & c_sext)
               | ({BITS{dp.INTERout}} & inter_lo_q)
               | ({BITS{dp.Rout}}     & rx_val)
               | ({BITS{dp.BAout && rx_sel != 4'd0}} & rx_val);
        bus_hi = ({BITS{dp.HILOout}}  & hi_q)
               | ({BITS{dp.RZout}}    & rz_q[2*BITS-1:BITS])
               | ({BITS{dp.INTERout}} & inter_hi_q);
    end

    logic [BITS-1:0]   alu_a, alu_b, quot, rem;
    logic [2*BITS-1:0] alu_res, prod, rot_r, rot_l;
    logic [4:0]        sh;

    assign alu_a = ry_q;
    assign alu_b = bus_lo;
    assign sh    = alu_b[4:0];
    assign prod  = $signed({{BITS{alu_a[BITS-1]}}, alu_a}) * $signed({{BITS{alu_b[BITS-1]}}, alu_b});
    assign quot  = (alu_b == '0) ? '1 : $signed(alu_a) / $signed(alu_b);
    assign rem   = (alu_b == '0) ? alu_a : $signed(alu_a) % $signed(alu_b);
    assign rot_r = {alu_a, alu_a} >> sh;
    assign rot_l = {alu_a, alu_a} << sh;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        alu_res = '0;
        if (dp.ADD)         alu_res = {{BITS{1'b0}}, alu_a + alu_b};
        else if (dp.SUB)    alu_res = {{BITS{1'b0}}, alu_a - alu_b};
        else if (dp.MUL)    alu_res = prod;
        else if (dp.DIV)    alu_res = {rem, quot};
        else if (dp.SHR)    alu_res = {{BITS{1'b0}}, alu_a >> sh};
        else if (dp.SHL)    alu_res = {{BITS{1'b0}}, alu_a << sh};
        else if (dp.ROR)    alu_res = {{BITS{1'b0}}, rot_r[BITS-1:0]};
        else if (dp.ROL)    alu_res = {{BITS{1'b0}}, rot_l[2*BITS-1:BITS]};
        else if (dp.AND)    alu_res = {{BITS{1'b0}}, alu_a & alu_b};
        else if (dp.OR)     alu_res = {{BITS{1'b0}}, alu_a | alu_b};
        else if (dp.NEGATE) alu_res = {{BITS{1'b0}}, -alu_b};
        else if (dp.NOT)    alu_res = {{BITS{1'b0}}, ~alu_b};
        else if (dp.IncPC)  alu_res = {{BITS{1'b0}}, alu_b + 1'b1};
    end

    always_comb begin
        for (int i = 0; i < REGISTERS; i++) r_d[i] = r_q[i];
        pc_d       = dp.PCin     ? bus_lo : pc_q;
        ir_d       = dp.IRin     ? bus_lo : ir_q;
        mar_d      = dp.MARin    ? bus_lo : mar_q;
        ry_d       = dp.RYin     ? bus_lo : ry_q;
        out_d      = dp.OUTPUTin ? bus_lo : out_q;
        lo_d       = dp.HILOin   ? bus_lo : lo_q;
        hi_d       = dp.HILOin   ? bus_hi : hi_q;
        inter_lo_d = dp.INTERin  ? bus_lo : inter_lo_q;
        inter_hi_d = dp.INTERin  ? bus_hi : inter_hi_q;
        rz_d       = dp.RZin     ? alu_res : rz_q;
        mdr_d      = dp.MDRin    ? (dp.Read ? ram_rd : bus_lo) : mdr_q;
        con_d      = con_q;
        if (dp.CONin) begin
            unique case (c2)
                2'b00: con_d = (bus_lo == '0);
                2'b01: con_d = (bus_lo != '0);
                2'b10: con_d = ~bus_lo[BITS-1];
                2'b11: con_d = bus_lo[BITS-1];
            endcase
        end
        if (dp.Rin) r_d[rx_sel] = bus_lo;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge values; a same-edge read of a register sees its old contents.
        if (reset) begin
            for (int i = 0; i < REGISTERS; i++) r_q[i] <= '0;
            pc_q <= '0; ir_q <= '0; mar_q <= '0; mdr_q <= '0; ry_q <= '0;
            hi_q <= '0; lo_q <= '0; inter_hi_q <= '0; inter_lo_q <= '0;
            out_q <= '0; rz_q <= '0; con_q <= 1'b0;
        end else begin
            for (int i = 0; i < REGISTERS; i++) r_q[i] <= r_d[i];
            pc_q <= pc_d; ir_q <= ir_d; mar_q <= mar_d; mdr_q <= mdr_d; ry_q <= ry_d;
            hi_q <= hi_d; lo_q <= lo_d; inter_hi_q <= inter_hi_d; inter_lo_q <= inter_lo_d;
            out_q <= out_d; rz_q <= rz_d; con_q <= con_d;
        end
    end

    // NOTE: the RAM array has no reset branch; its contents survive reset and it
    // maps onto plain memory. Only the write strobe is blocked while reset is high.
    always_ff @(posedge clk) begin
        if (dp.Write && !reset) ram[mar_idx] <= mdr_q;
    end

    always_comb begin
        dp.regSelectStreamLO = '0;
        dp.regSelectStreamHI = '0;
        for (int i = 0; i < REGISTERS; i++) dp.regSelectStreamLO[i*BITS +: BITS] = r_q[i];
        dp.regSelectStreamLO[(REGISTERS+0)*BITS +: BITS] = pc_q;
        dp.regSelectStreamLO[(REGISTERS+1)*BITS +: BITS] = ir_q;
        dp.regSelectStreamLO[(REGISTERS+2)*BITS +: BITS] = mar_q;
        dp.regSelectStreamLO[(REGISTERS+3)*BITS +: BITS] = mdr_q;
        dp.regSelectStreamLO[(REGISTERS+4)*BITS +: BITS] = ry_q;
        dp.regSelectStreamLO[(REGISTERS+5)*BITS +: BITS] = rz_q[BITS-1:0];
        dp.regSelectStreamLO[(REGISTERS+6)*BITS +: BITS] = lo_q;
        dp.regSelectStreamHI[(REGISTERS+5)*BITS +: BITS] = rz_q[2*BITS-1:BITS];
        dp.regSelectStreamHI[(REGISTERS+6)*BITS +: BITS] = hi_q;
    end

    assign dp.busLO           = bus_lo;
    assign dp.busHI           = bus_hi;
    assign dp.MARVal          = mar_q;
    assign dp.IRVal           = ir_q;
    assign dp.MDRVal          = mdr_q;
    assign dp.LOVal           = lo_q;
    assign dp.HIVal           = hi_q;
    assign dp.INTERHIVal      = inter_hi_q;
    assign dp.INTERLOVal      = inter_lo_q;
    assign dp.RZVal           = rz_q;
    assign dp.OUTPUTUnit      = out_q;
    assign dp.c_sign_extended = c_sext;
    assign dp.CON             = con_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: stimulus pushes expected observations into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_cpu_datapath;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rclk = 1'b0;
    always #5 clk = ~clk;

    cpu_datapath_if dp_if ();
    cpu_datapath dut (.reset(reset), .clk(clk), .rClk(rclk), .dp(dp_if));

    typedef enum {
        OB_BUSLO, OB_BUSHI, OB_PC, OB_IR, OB_MAR, OB_MDR, OB_RY, OB_RZLO, OB_RZHI,
        OB_HI, OB_LO, OB_IHI, OB_ILO, OB_OUT, OB_CSE, OB_CON, OB_R, OB_SHI
    } obs_e;

    typedef struct {
        obs_e        sel;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] observe(obs_e sel, int idx);
        case (sel)
            OB_BUSLO: return dp_if.busLO;
            OB_BUSHI: return dp_if.busHI;
            OB_PC:    return dp_if.regSelectStreamLO[16*32 +: 32];
            OB_IR:    return dp_if.IRVal;
            OB_MAR:   return dp_if.MARVal;
            OB_MDR:   return dp_if.MDRVal;
            OB_RY:    return dp_if.regSelectStreamLO[20*32 +: 32];
            OB_RZLO:  return dp_if.RZVal[31:0];
            OB_RZHI:  return dp_if.RZVal[63:32];
            OB_HI:    return dp_if.HIVal;
            OB_LO:    return dp_if.LOVal;
            OB_IHI:   return dp_if.INTERHIVal;
            OB_ILO:   return dp_if.INTERLOVal;
            OB_OUT:   return dp_if.OUTPUTUnit;
            OB_CSE:   return dp_if.c_sign_extended;
            OB_CON:   return {31'b0, dp_if.CON};
            OB_R:     return dp_if.regSelectStreamLO[idx*32 +: 32];
            OB_SHI:   return dp_if.regSelectStreamHI[idx*32 +: 32];
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] got;
            e   = exp_q.pop_front();
            got = observe(e.sel, e.idx);
            n_tests++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.val);
            end
        end
    end

    task automatic push(input obs_e sel, input int idx, input logic [31:0] val, input string name);
        exp_t e;
        e.sel = sel; e.idx = idx; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic clear_ctrl();
        dp_if.CONin = 0; dp_if.PCin = 0; dp_if.IRin = 0; dp_if.RYin = 0; dp_if.RZin = 0;
        dp_if.MARin = 0; dp_if.HILOin = 0; dp_if.OUTPUTin = 0; dp_if.INTERin = 0; dp_if.MDRin = 0;
        dp_if.Read = 0; dp_if.Write = 0;
        dp_if.INPUTout = 0; dp_if.MDRout = 0; dp_if.HILOout = 0; dp_if.RZout = 0; dp_if.PCout = 0;
        dp_if.Cout = 0; dp_if.INTERout = 0; dp_if.BAout = 0; dp_if.Rout = 0;
        dp_if.Gra = 0; dp_if.Grb = 0; dp_if.Grc = 0; dp_if.Rin = 0;
        dp_if.ADD = 0; dp_if.SUB = 0; dp_if.MUL = 0; dp_if.DIV = 0; dp_if.SHR = 0; dp_if.SHL = 0;
        dp_if.ROR = 0; dp_if.ROL = 0; dp_if.AND = 0; dp_if.OR = 0; dp_if.NEGATE = 0; dp_if.NOT = 0;
        dp_if.IncPC = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic in_val(input logic [31:0] v);
        dp_if.INPUTUnit = v;
        dp_if.INPUTout  = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ctrl();
        dp_if.INPUTUnit = '0;
        reset = 1;
        tick();
        reset = 0;
        push(OB_PC, 0, 32'h0, "reset_pc");
        push(OB_IR, 0, 32'h0, "reset_ir");
        push(OB_RZLO, 0, 32'h0, "reset_rz");
        push(OB_CON, 0, 32'h0, "reset_con");
        push(OB_OUT, 0, 32'h0, "reset_out");
        push(OB_R, 5, 32'h0, "reset_r5");
        push(OB_BUSLO, 0, 32'h0, "idle_buslo");

        // RAM[0] = load-constant instruction: Ra=2, C=0x7FFFF
        in_val(32'h0); dp_if.MARin = 1; tick();
        in_val(32'h0107_FFFF); dp_if.MDRin = 1; push(OB_BUSLO, 0, 32'h0107_FFFF, "bus_input"); tick();
        dp_if.Write = 1; tick();

        // Fetch
        dp_if.PCout = 1; dp_if.IncPC = 1; dp_if.RZin = 1; dp_if.MARin = 1; tick();
        push(OB_RZLO, 0, 32'h1, "fetch_rz"); push(OB_MAR, 0, 32'h0, "fetch_mar");
        dp_if.RZout = 1; dp_if.PCin = 1; dp_if.Read = 1; dp_if.MDRin = 1;
        push(OB_BUSLO, 0, 32'h1, "fetch_buslo"); push(OB_BUSHI, 0, 32'h0, "fetch_bushi"); tick();
        push(OB_PC, 0, 32'h1, "fetch_pc"); push(OB_MDR, 0, 32'h0107_FFFF, "fetch_mdr");
        dp_if.MDRout = 1; dp_if.IRin = 1; tick();
        push(OB_IR, 0, 32'h0107_FFFF, "fetch_ir"); push(OB_CSE, 0, 32'hFFFF_FFFF, "c_sext");

        // Load constant, jump register
        dp_if.Gra = 1; dp_if.Rin = 1; dp_if.Cout = 1; push(OB_BUSLO, 0, 32'hFFFF_FFFF, "cout_bus"); tick();
        push(OB_R, 2, 32'hFFFF_FFFF, "ldc_r2");
        in_val(32'h25); dp_if.Gra = 1; dp_if.Rin = 1; tick();
        dp_if.Gra = 1; dp_if.Rout = 1; dp_if.PCin = 1; push(OB_BUSLO, 0, 32'h25, "jr_bus"); tick();
        push(OB_PC, 0, 32'h25, "jr_pc");

        // ALU
        in_val(32'd7); dp_if.RYin = 1; tick(); push(OB_RY, 0, 32'd7, "ry7");
        in_val(32'hFFFF_FFFD); dp_if.MUL = 1; dp_if.RZin = 1; tick();
        push(OB_RZLO, 0, 32'hFFFF_FFEB, "mul_lo"); push(OB_RZHI, 0, 32'hFFFF_FFFF, "mul_hi");
        dp_if.RZout = 1; dp_if.HILOin = 1; dp_if.INTERin = 1; push(OB_BUSHI, 0, 32'hFFFF_FFFF, "rz_bushi"); tick();
        push(OB_LO, 0, 32'hFFFF_FFEB, "hilo_lo"); push(OB_HI, 0, 32'hFFFF_FFFF, "hilo_hi");
        push(OB_SHI, 22, 32'hFFFF_FFFF, "stream_hi22"); push(OB_SHI, 21, 32'hFFFF_FFFF, "stream_hi21");
        push(OB_SHI, 3, 32'h0, "stream_hi3");
        push(OB_IHI, 0, 32'hFFFF_FFFF, "inter_hi"); push(OB_ILO, 0, 32'hFFFF_FFEB, "inter_lo");
        in_val(32'd2); dp_if.DIV = 1; dp_if.RZin = 1; tick();
        push(OB_RZLO, 0, 32'd3, "div_q"); push(OB_RZHI, 0, 32'd1, "div_r");
        in_val(32'd0); dp_if.DIV = 1; dp_if.RZin = 1; tick();
        push(OB_RZLO, 0, 32'hFFFF_FFFF, "div0_q"); push(OB_RZHI, 0, 32'd7, "div0_r");
        in_val(32'd1); dp_if.RYin = 1; tick();
        in_val(32'd1); dp_if.ROR = 1; dp_if.RZin = 1; tick();
        push(OB_RZLO, 0, 32'h8000_0000, "ror_lo"); push(OB_RZHI, 0, 32'h0, "ror_hi");
        in_val(32'd5); dp_if.SUB = 1; dp_if.RZin = 1; tick();
        push(OB_RZLO, 0, 32'hFFFF_FFFC, "sub_lo"); push(OB_RZHI, 0, 32'h0, "sub_hi");
        in_val(32'h21); dp_if.SHL = 1; dp_if.RZin = 1; tick();
        push(OB_RZLO, 0, 32'h2, "shl_5bit");

        // Memory write, readback, aliasing
        in_val(32'd5); dp_if.MARin = 1; tick();
        in_val(32'hDEAD); dp_if.MDRin = 1; tick();
        dp_if.Write = 1; tick();
        in_val(32'h0); dp_if.MDRin = 1; tick(); push(OB_MDR, 0, 32'h0, "mdr_clear");
        dp_if.Read = 1; dp_if.MDRin = 1; tick(); push(OB_MDR, 0, 32'hDEAD, "ram_read");
        in_val(32'd517); dp_if.MARin = 1; tick();
        in_val(32'h0); dp_if.MDRin = 1; tick();
        dp_if.Read = 1; dp_if.MDRin = 1; tick(); push(OB_MDR, 0, 32'hDEAD, "ram_alias");

        // CON with C2=01, BAout of R0
        in_val(32'h0008_0000); dp_if.IRin = 1; tick();
        in_val(32'd5); dp_if.CONin = 1; tick(); push(OB_CON, 0, 32'h1, "con_ne_true");
        dp_if.CONin = 1; tick(); push(OB_CON, 0, 32'h0, "con_ne_false");
        in_val(32'h99); dp_if.Gra = 1; dp_if.Rin = 1; tick(); push(OB_R, 0, 32'h99, "r0_write");
        dp_if.Gra = 1; dp_if.BAout = 1; push(OB_BUSLO, 0, 32'h0, "baout_r0"); tick();
        dp_if.Gra = 1; dp_if.Rout = 1; push(OB_BUSLO, 0, 32'h99, "rout_r0"); tick();
        in_val(32'hABCD); dp_if.OUTPUTin = 1; tick(); push(OB_OUT, 0, 32'hABCD, "out_port");

        // Reset wins over a simultaneous load; RAM survives
        reset = 1; in_val(32'h55); dp_if.PCin = 1; tick(); reset = 0;
        push(OB_PC, 0, 32'h0, "rst_pc"); push(OB_R, 0, 32'h0, "rst_r0"); push(OB_R, 2, 32'h0, "rst_r2");
        push(OB_RZLO, 0, 32'h0, "rst_rz"); push(OB_HI, 0, 32'h0, "rst_hi"); push(OB_OUT, 0, 32'h0, "rst_out");
        push(OB_CON, 0, 32'h0, "rst_con"); push(OB_MAR, 0, 32'h0, "rst_mar"); push(OB_IR, 0, 32'h0, "rst_ir");
        in_val(32'd5); dp_if.MARin = 1; tick();
        dp_if.Read = 1; dp_if.MDRin = 1; tick(); push(OB_MDR, 0, 32'hDEAD, "ram_kept");

        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
